// File: rtl/demux1to8_reg_b32_if.sv
// Bus bundle for demux1to8_reg_b32: select/data/request inputs and registered destination words.
// The bcast qualifier exists only when DEMUX_BCAST_EN is defined.
interface demux1to8_reg_b32_if;
  logic        C2;
  logic        C1;
  logic        C0;
  logic [31:0] I;
  logic        we;
  logic        start_seq;
`ifdef DEMUX_BCAST_EN
  logic        bcast;
`endif
  logic        busy;
  logic [7:0]  strb;
  logic [31:0] O0;
  logic [31:0] O1;
  logic [31:0] O2;
  logic [31:0] O3;
  logic [31:0] O4;
  logic [31:0] O5;
  logic [31:0] O6;
  logic [31:0] O7;

  modport master (
`ifdef DEMUX_BCAST_EN
    output bcast,
`endif
    output C2, C1, C0, I, we, start_seq,
    input  busy, strb, O0, O1, O2, O3, O4, O5, O6, O7
  );

  modport slave (
`ifdef DEMUX_BCAST_EN
    input  bcast,
`endif
    input  C2, C1, C0, I, we, start_seq,
    output busy, strb, O0, O1, O2, O3, O4, O5, O6, O7
  );
endinterface

// File: rtl/demux1to8_reg_b32.sv
// 1-to-8 registered 32-bit demux with single writes and an 8-word wrapping sequential fill.
// Optional broadcast write enabled by defining DEMUX_BCAST_EN.
module demux1to8_reg_b32 (
  input logic              clk,
  input logic              reset,
  demux1to8_reg_b32_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StSeq} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sel;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  rem_q, rem_d;
  logic [7:0]  wr_en;
  logic [7:0]  strb_q, strb_d;
  logic [31:0] o_q [8];
  logic [31:0] o_d [8];
  logic        busy;
  logic        bcast_req;

  assign sel = {bus.C2, bus.C1, bus.C0};

`ifdef DEMUX_BCAST_EN
  assign bcast_req = bus.bcast;
`else
  assign bcast_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave SEQ on the edge that makes the eighth write (remaining count 1 -> 0).
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start_seq) state_d = StSeq;
      StSeq:   if (rem_q == 3'd1) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_en = 8'h00;
    cnt_d = cnt_q;
    rem_d = rem_q;
    busy  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start_seq) begin
          wr_en = 8'b1 << sel;
          cnt_d = sel + 3'd1;
          rem_d = 3'd7;
        end else if (bus.we) begin
          wr_en = bcast_req ? 8'hFF : (8'b1 << sel);
        end
      end
      StSeq: begin
        busy  = 1'b1;
        wr_en = 8'b1 << cnt_q;
        cnt_d = cnt_q + 3'd1;
        rem_d = rem_q - 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    strb_d = wr_en;
    for (int n = 0; n < 8; n++) begin
      o_d[n] = wr_en[n] ? bus.I : o_q[n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 3'd0;
      rem_q  <= 3'd0;
      strb_q <= 8'h00;
      for (int n = 0; n < 8; n++) begin
        o_q[n] <= 32'h0;
      end
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      strb_q <= strb_d;
      for (int n = 0; n < 8; n++) begin
        o_q[n] <= o_d[n];
      end
    end
  end

  assign bus.busy = busy;
  assign bus.strb = strb_q;
  assign bus.O0   = o_q[0];
  assign bus.O1   = o_q[1];
  assign bus.O2   = o_q[2];
  assign bus.O3   = o_q[3];
  assign bus.O4   = o_q[4];
  assign bus.O5   = o_q[5];
  assign bus.O6   = o_q[6];
  assign bus.O7   = o_q[7];

endmodule
